// File: rtl/burst_mem_responder_pkg.sv
// Shared types, widths and helpers for the 4-beat x 64-bit line burst responder.
package mem_burst_pkg;

    localparam int unsigned BEAT_W      = 64;
    localparam int unsigned LINE_W      = 256;
    localparam int unsigned BEATS       = LINE_W / BEAT_W;
    localparam int unsigned BEAT_IDX_W  = $clog2(BEATS);
    localparam int unsigned OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StBeat,
        StDone
    } state_e;

    // Line index from a byte address; upper bits beyond the store depth wrap.
    function automatic int unsigned line_index(input logic [31:0] addr,
                                               input int unsigned depth);
        return 32'(addr >> OFFSET_BITS) & (depth - 1);
    endfunction

endpackage

// File: rtl/burst_mem_responder_if.sv
// Request/beat bus between the line initiator (master) and the memory responder (slave).
interface burst_mem_responder_if;
    import mem_burst_pkg::*;

    logic [31:0]       address_i;
    logic              read_i;
    logic              write_i;
    logic [BEAT_W-1:0] burst_i;
    logic [BEAT_W-1:0] burst_o;
    logic              resp_o;

    modport master (
        output address_i,
        output read_i,
        output write_i,
        output burst_i,
        input  burst_o,
        input  resp_o
    );

    modport slave (
        input  address_i,
        input  read_i,
        input  write_i,
        input  burst_i,
        output burst_o,
        output resp_o
    );

endinterface

// File: rtl/burst_mem_responder_line_store.sv
// Line backing store held as beats: async beat read port, sync beat write port,
// both addressed by {line index, beat}. Contents are deliberately not reset.
module line_store
    import mem_burst_pkg::*;
#(
    parameter int unsigned DepthLines = 64,
    localparam int unsigned AddrW     = $clog2(DepthLines) + BEAT_IDX_W
) (
    input  logic              clk,
    input  logic [AddrW-1:0]  rd_addr_i,
    output logic [BEAT_W-1:0] rd_data_o,
    input  logic              we_i,
    input  logic [AddrW-1:0]  wr_addr_i,
    input  logic [BEAT_W-1:0] wr_data_i
);

    logic [BEAT_W-1:0] mem_q [DepthLines*BEATS];

    // Commit one write beat per enabled edge.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read data is valid in the same cycle as the address.
    always_comb begin
        rd_data_o = mem_q[rd_addr_i];
    end

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for line bursts: accepts a read/write request, waits LATENCY
// cycles, then streams or absorbs four 64-bit beats with resp_o high on each.
module burst_mem_responder
    import mem_burst_pkg::*;
#(
    parameter int unsigned LATENCY     = 4,
    parameter int unsigned DEPTH_LINES = 64
) (
    input logic                  clk,
    input logic                  reset_n,
    burst_mem_responder_if.slave bus
);

    localparam int unsigned IdxW    = $clog2(DEPTH_LINES);
    localparam logic [7:0]  LatLast = (LATENCY > 0) ? 8'(LATENCY - 1) : 8'd0;

    state_e                state_q, state_d;
    logic [7:0]            lat_cnt_q, lat_cnt_d;
    logic [BEAT_IDX_W-1:0] beat_q, beat_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic                  op_wr_q, op_wr_d;

    logic                     req;
    logic                     beat_vld;
    logic                     store_we;
    logic [IdxW+BEAT_IDX_W-1:0] store_addr;
    logic [BEAT_W-1:0]        rd_data;

    assign req        = bus.read_i | bus.write_i;
    assign store_addr = {idx_q, beat_q};

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a dropped request aborts WAIT/BEAT; DONE holds until the request falls.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = (LATENCY > 0) ? StWait : StBeat;
                end
            end
            StWait: begin
                if (!req) begin
                    state_d = StDone;
                end else if (lat_cnt_q == LatLast) begin
                    state_d = StBeat;
                end
            end
            StBeat: begin
                if (!req || (beat_q == BEAT_IDX_W'(BEATS - 1))) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!req) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Counter and request-latch next values; op and index are frozen after acceptance.
    always_comb begin
        lat_cnt_d = lat_cnt_q;
        beat_d    = beat_q;
        idx_d     = idx_q;
        op_wr_d   = op_wr_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    idx_d     = IdxW'(line_index(bus.address_i, DEPTH_LINES));
                    op_wr_d   = bus.write_i;
                    lat_cnt_d = 8'd0;
                    beat_d    = '0;
                end
            end
            StWait:  lat_cnt_d = lat_cnt_q + 8'd1;
            StBeat:  beat_d    = beat_q + BEAT_IDX_W'(1);
            default: ;
        endcase
    end

    // Counter and request-latch registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lat_cnt_q <= 8'd0;
            beat_q    <= '0;
            idx_q     <= '0;
            op_wr_q   <= 1'b0;
        end else begin
            lat_cnt_q <= lat_cnt_d;
            beat_q    <= beat_d;
            idx_q     <= idx_d;
            op_wr_q   <= op_wr_d;
        end
    end

    // Outputs: beats only while the request is still held; a reset edge blocks the commit.
    always_comb begin
        beat_vld    = (state_q == StBeat) && req;
        bus.resp_o  = beat_vld;
        bus.burst_o = (beat_vld && !op_wr_q) ? rd_data : '0;
        store_we    = beat_vld && op_wr_q && reset_n;
    end

    line_store #(
        .DepthLines (DEPTH_LINES)
    ) u_line_store (
        .clk       (clk),
        .rd_addr_i (store_addr),
        .rd_data_o (rd_data),
        .we_i      (store_we),
        .wr_addr_i (store_addr),
        .wr_data_i (bus.burst_i)
    );

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench: two responders (LATENCY=4 and LATENCY=0) sharing one stimulus set,
// with requests steered to one at a time.
module tb_burst_mem_responder;
    import mem_burst_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic              rd = 1'b0;
    logic              wr = 1'b0;
    logic [31:0]       addr = '0;
    logic [BEAT_W-1:0] wdata = '0;
    logic              use0 = 1'b0;

    burst_mem_responder_if if4 ();
    burst_mem_responder_if if0 ();

    assign if4.address_i = addr;
    assign if4.burst_i   = wdata;
    assign if4.read_i    = rd & ~use0;
    assign if4.write_i   = wr & ~use0;
    assign if0.address_i = addr;
    assign if0.burst_i   = wdata;
    assign if0.read_i    = rd & use0;
    assign if0.write_i   = wr & use0;

    logic              resp;
    logic [BEAT_W-1:0] rdata;
    assign resp  = use0 ? if0.resp_o : if4.resp_o;
    assign rdata = use0 ? if0.burst_o : if4.burst_o;

    burst_mem_responder #(.LATENCY(4), .DEPTH_LINES(64)) u_dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if4.slave)
    );

    burst_mem_responder #(.LATENCY(0), .DEPTH_LINES(64)) u_dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if0.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full transaction on the selected responder, starting and ending at a negedge
    // with the responder idle. Checks first-beat latency, 4 beats, and quiet DONE.
    task automatic run_txn(input string tag, input logic do_rd, input logic do_wr,
                           input logic [31:0] a, input logic [LINE_W-1:0] wline,
                           input int hold, output logic [LINE_W-1:0] rline);
        int  n;
        int  exp_lat;
        bit  got;
        exp_lat = use0 ? 1 : 5;
        rline   = '0;
        rd      = do_rd;
        wr      = do_wr;
        addr    = a;
        got     = 1'b0;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (resp) begin
                got = 1'b1;
                break;
            end
        end
        check_eq({tag, "_lat"}, 64'(n), 64'(exp_lat));
        if (!got) begin
            rd = 1'b0;
            wr = 1'b0;
            repeat (2) @(negedge clk);
            return;
        end
        for (int b = 0; b < 4; b++) begin
            check_eq($sformatf("%s_resp%0d", tag, b), 64'(resp), 64'd1);
            if (do_wr) begin
                check_eq($sformatf("%s_wrbus%0d", tag, b), rdata, 64'd0);
            end
            rline[64*b +: 64] = rdata;
            wdata = wline[64*b +: 64];
            @(negedge clk);
        end
        check_eq({tag, "_done"}, 64'(resp), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq($sformatf("%s_hold%0d", tag, h), 64'(resp), 64'd0);
        end
        rd = 1'b0;
        wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_line(input string tag, input logic [LINE_W-1:0] got,
                              input logic [LINE_W-1:0] exp);
        for (int b = 0; b < 4; b++) begin
            check_eq($sformatf("%s_b%0d", tag, b), got[64*b +: 64], exp[64*b +: 64]);
        end
    endtask

    logic [LINE_W-1:0] line_a, line_e, line_f, line_g, line_h, line_j, line_k, rl, expl;

    initial begin
        line_a = {64'hD, 64'hC, 64'hB, 64'hA};
        line_e = {64'hE3E3_0000_0000_0003, 64'hE2E2_0000_0000_0002,
                  64'hE1E1_0000_0000_0001, 64'hE0E0_0000_0000_0000};
        line_f = {64'hF3F3_1234_5678_9ABC, 64'hF2F2_1234_5678_9ABC,
                  64'hF1F1_1234_5678_9ABC, 64'hF0F0_1234_5678_9ABC};
        line_g = {64'h6666_0000_0000_0033, 64'h6666_0000_0000_0022,
                  64'h6666_0000_0000_0011, 64'h6666_0000_0000_0000};
        line_h = {64'h4444_0000_0000_0003, 64'h4444_0000_0000_0002,
                  64'h4444_0000_0000_0001, 64'h4444_0000_0000_0000};
        line_j = {64'hAAAA_0000_0000_0003, 64'hAAAA_0000_0000_0002,
                  64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0000};
        line_k = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                  64'h5555_AAAA_5555_AAAA, 64'h1111_2222_3333_4444};

        repeat (3) @(negedge clk);
        check_eq("rst_resp4", 64'(if4.resp_o), 64'd0);
        check_eq("rst_burst4", if4.burst_o, 64'd0);
        check_eq("rst_resp0", 64'(if0.resp_o), 64'd0);
        check_eq("rst_state4", 64'(u_dut4.state_q), 64'(StIdle));
        reset_n = 1'b1;
        @(negedge clk);

        // Write then read, LATENCY=4.
        use0 = 1'b0;
        run_txn("wr40", 1'b0, 1'b1, 32'h40, line_a, 0, rl);
        run_txn("rd40", 1'b1, 1'b0, 32'h40, '0, 0, rl);
        check_line("rd40", rl, line_a);

        // LATENCY=0 responder.
        use0 = 1'b1;
        run_txn("wr0_l0", 1'b0, 1'b1, 32'h0, line_k, 0, rl);
        run_txn("rd0_l0", 1'b1, 1'b0, 32'h0, '0, 0, rl);
        check_line("rd0_l0", rl, line_k);
        use0 = 1'b0;

        // Both request lines high means write; old contents are replaced.
        run_txn("wr60", 1'b0, 1'b1, 32'h60, line_e, 0, rl);
        run_txn("both60", 1'b1, 1'b1, 32'h60, line_f, 0, rl);
        run_txn("rd60", 1'b1, 1'b0, 32'h60, '0, 0, rl);
        check_line("rd60", rl, line_f);

        // Request held through DONE: no re-acceptance, then a fresh read is accepted.
        run_txn("hold", 1'b1, 1'b0, 32'h40, '0, 3, rl);
        check_line("hold", rl, line_a);
        run_txn("after_hold", 1'b1, 1'b0, 32'h40, '0, 0, rl);
        check_line("after_hold", rl, line_a);

        // Address wrap: 0x81F maps to line 0.
        run_txn("wr81f", 1'b0, 1'b1, 32'h81F, line_g, 0, rl);
        run_txn("rd0wrap", 1'b1, 1'b0, 32'h0, '0, 0, rl);
        check_line("rd0wrap", rl, line_g);

        // Reset during beat 2 of a write to 0x20.
        run_txn("wr20old", 1'b0, 1'b1, 32'h20, line_h, 0, rl);
        wr   = 1'b1;
        addr = 32'h20;
        begin : wait_first_beat
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (resp) disable wait_first_beat;
            end
            check_eq("rstmid_timeout", 64'(resp), 64'd1);
        end
        wdata = line_j[63:0];
        @(negedge clk);
        wdata = line_j[127:64];
        @(negedge clk);
        check_eq("rstmid_beat2", 64'(resp), 64'd1);
        wdata   = line_j[191:128];
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("rstmid_resp", 64'(resp), 64'd0);
        check_eq("rstmid_state", 64'(u_dut4.state_q), 64'(StIdle));
        reset_n = 1'b1;
        wr      = 1'b0;
        @(negedge clk);
        run_txn("rd20", 1'b1, 1'b0, 32'h20, '0, 0, rl);
        expl = {line_h[255:128], line_j[127:0]};
        check_line("rd20", rl, expl);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/burst_mem_responder.md
Name: burst_mem_responder

Overview:
Memory-side responder for the 4-beat x 64-bit burst protocol that the LLC cacheline adaptor initiates. It accepts a line read or write request, waits a programmable latency, then streams or absorbs four consecutive 64-bit beats, asserting resp_o on each beat. It holds a synthesizable line-organised backing store, so it serves both as the physical-memory model for cache-hierarchy benches and as an on-chip line RAM.

Parameters:
LATENCY, 4, idle cycles between request acceptance and the first beat; legal range 0..255.
DEPTH_LINES, 64, number of 256-bit lines in the backing store; must be a power of 2 and at least 2.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset_n  input  1  synchronous, active-low reset.
address_i  input  32  byte address of the line; bits [4:0] are ignored.
read_i  input  1  line read request; held high by the initiator until after the final beat.
write_i  input  1  line write request; held high by the initiator until after the final beat.
burst_i  input  64  write beat data; sampled on each cycle in which resp_o=1 during a write.
burst_o  output  64  read beat data; valid in each cycle in which resp_o=1 during a read, otherwise 0.
resp_o  output  1  beat strobe; high for exactly 4 consecutive cycles per transaction.

Behaviour:
- Reset (reset_n=0 at a clock edge): state goes to IDLE, the latency counter and beat counter go to 0, resp_o=0, burst_o=0. Backing-store contents are not cleared. A reset asserted mid-burst aborts the transaction; write beats already committed remain in the store.
- States: IDLE, WAIT, BEAT, DONE.
- IDLE, with read_i or write_i high:
  - Latch line index = address_i[5 +: log2(DEPTH_LINES)]; upper address bits wrap (ignored).
  - Latch op: write if write_i=1, otherwise read. Write wins when both are high.
  - Go to WAIT if LATENCY>0, otherwise go to BEAT. Latency counter and beat counter are set to 0.
- WAIT: increment the latency counter each cycle; when it reaches LATENCY-1, go to BEAT. The first beat therefore appears LATENCY+1 cycles after the accepting edge.
- BEAT:
  - resp_o=1 every cycle; the beat counter b runs 0,1,2,3 and increments on each edge.
  - Read: burst_o = mem[idx][64*b +: 64], a combinational read of the store, so data is valid in the same cycle as resp_o.
  - Write: mem[idx][64*b +: 64] <= burst_i at the edge ending the beat cycle.
  - Beat 0 carries line bits [63:0]; beat 3 carries bits [255:192].
  - After b=3, go to DONE.
- DONE: resp_o=0. Stay in DONE while read_i or write_i is high, so a still-held request is never re-accepted. Return to IDLE on the first cycle both are low.
- Request dropped (read_i=0 and write_i=0) during WAIT or BEAT: abort to DONE with no further beats; partial write beats remain committed.
- The latched op and index are not affected by changes on address_i, read_i or write_i after acceptance.
- Back-to-back transactions: minimum spacing is one DONE cycle plus one IDLE acceptance cycle.
- Read-after-write to the same line returns the new data, since the write commits before DONE.

Decomposition:
- Package mem_burst_pkg holds:
  - the state enum typedef;
  - localparams BEATS=4, BEAT_W=64, LINE_W=256, OFFSET_BITS=5;
  - function line_index(addr, depth).
- One sub-module, line_store: DEPTH_LINES x 256-bit array with an asynchronous 64-bit beat read port and a synchronous 64-bit beat write port, both addressed by {idx, beat}.
- The FSM, counters and handshake logic stay in the top module.

Test Plan:
- Write then read, LATENCY=4: write_i=1, address 0x40, line = {64'hD, 64'hC, 64'hB, 64'hA}. Required: resp_o first high 5 cycles after acceptance, high for 4 cycles. Then read_i at 0x40 -> burst_o = A, B, C, D on consecutive resp_o cycles.
- LATENCY=0: read request at 0x0 -> resp_o high on the cycle immediately after acceptance, 4 cycles long, burst_o = stored beats 0..3 in order.
- Simultaneous read_i=1 and write_i=1: treated as a write. A later read of that line returns the written data and the previous line contents are gone.
- Request held high through DONE for 3 cycles: exactly 4 resp_o pulses total, no second transaction; the next request is accepted only after read_i drops.
- Address wrap, DEPTH_LINES=64: write 0x800 (line index 0) -> a read of 0x0 returns the same data; bits [4:0]=0x1F ignored.
- reset_n=0 during beat 2 of a write to 0x20: resp_o=0 the following cycle and the FSM is in IDLE. A subsequent read of 0x20 returns new beats 0..1 and old beats 2..3.
